// File: rtl/ce_step_gen_if.sv
// Control bundle between the board-side mode/button inputs and the counter chain.
// The master drives mode and raw buttons; the slave (ce_step_gen) returns ce, R and tick.
interface ce_step_gen_if;
    logic [1:0] mode;
    logic       btn_step;
    logic       btn_clr;
    logic       ce;
    logic       R;
    logic       tick;

    modport master (output mode, btn_step, btn_clr, input ce, R, tick);
    modport slave  (input mode, btn_step, btn_clr, output ce, R, tick);
endinterface

// File: rtl/ce_step_gen.sv
// Clock-enable and clear generator for the counter chain.
// Produces ce/R from a free-running prescaler or from debounced push-buttons.
module ce_step_gen #(
    parameter int DIV   = 50_000_000,
    parameter int DEB   = 500_000,
    parameter int DIV_W = 26,
    parameter int DEB_W = 19
) (
    input  logic             clk,
    input  logic             R_n,
    ce_step_gen_if.slave     bus
);

    typedef enum logic [1:0] {
        STOP = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        FAST = 2'b11
    } mode_t;

    mode_t            mode_q;
    logic [1:0]       raw;
    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic [1:0]       deb_lvl;
    logic [1:0]       deb_prev;
    logic [DEB_W-1:0] deb_cnt [2];
    logic [DIV_W-1:0] presc;
    logic             ce_q;
    logic             r_q;
    logic             tick_q;

    logic [1:0]       press;
    logic             presc_end;
    logic             mode_chg;
    logic             load;
    logic             ce_next;

    // Bit 0 is the step button, bit 1 the clear button.
    assign raw       = {bus.btn_clr, bus.btn_step};
    assign press     = deb_lvl & ~deb_prev;
    assign presc_end = (presc == DIV_W'(DIV - 1));
    assign mode_chg  = (mode_t'(bus.mode) != mode_q);
    assign load      = mode_chg | press[1];

    // A clear press or mode change suppresses ce, which also discards a coincident step press.
    always_comb begin
        ce_next = 1'b0;
        if (!load) begin
            unique case (mode_q)
                STOP: ce_next = 1'b0;
                RUN:  ce_next = presc_end;
                STEP: ce_next = press[0];
                FAST: ce_next = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            sync_a     <= '0;
            sync_b     <= '0;
            deb_lvl    <= '0;
            deb_prev   <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
            presc      <= '0;
            mode_q     <= STOP;
            ce_q       <= 1'b0;
            r_q        <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            sync_a   <= raw;
            sync_b   <= sync_a;
            deb_prev <= deb_lvl;
            // A new level is accepted only after DEB consecutive mismatching samples.
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != deb_lvl[i]) begin
                    if (deb_cnt[i] == DEB_W'(DEB - 1)) begin
                        deb_lvl[i] <= ~deb_lvl[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
            presc  <= (load || presc_end) ? '0 : presc + DIV_W'(1);
            mode_q <= mode_t'(bus.mode);
            ce_q   <= ce_next;
            r_q    <= press[1];
            tick_q <= presc_end;
        end
    end

    assign bus.ce   = ce_q;
    assign bus.R    = r_q;
    assign bus.tick = tick_q;

endmodule

// File: tb/tb_ce_step_gen.sv
// Self-checking bench for ce_step_gen: vector table, directed corner sequences and
// randomized traffic compared every cycle against a behavioural model.
module tb_ce_step_gen;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic clk = 1'b0;
    logic rn;

    always #10 clk = ~clk;

    ce_step_gen_if bus ();

    ce_step_gen #(.DIV(DIV), .DEB(DEB), .DIV_W(2), .DEB_W(2)) dut (
        .clk (clk),
        .R_n (rn),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] mode;
        logic       bs;
        logic       bc;
        logic       ce;
        logic       r;
        logic       tick;
    } vec_t;

    int testsRun    = 0;
    int testsFailed = 0;

    // Model state: prescaler phase, sampled mode, per-button raw history and debounce run.
    int         mPhase;
    logic [1:0] mModeQ;
    logic       mHist [2][2];
    int         mRun  [2];
    logic       mLvl  [2];
    logic       mPend [2];
    logic       eCe, eR, eTick;

    int   cyc;
    int   ceCount, ceFirst, rCount, rFirst;
    logic ceLog [$];

    task automatic checkVal(input string name, input int act, input int req);
        testsRun++;
        if (act != req) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic checkOutput(input string name);
        testsRun++;
        if ({bus.ce, bus.R, bus.tick} !== {eCe, eR, eTick}) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle %0d: got ce/R/tick=%b%b%b, expected %b%b%b",
                     name, cyc, bus.ce, bus.R, bus.tick, eCe, eR, eTick);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mModeQ = 2'b00;
        for (int b = 0; b < 2; b++) begin
            mHist[b][0] = 1'b0;
            mHist[b][1] = 1'b0;
            mRun[b]     = 0;
            mLvl[b]     = 1'b0;
            mPend[b]    = 1'b0;
        end
    endtask

    task automatic modelEdge(input logic [1:0] m, input logic bs, input logic bc);
        logic raw [2];
        logic ld;
        raw[0] = bs;
        raw[1] = bc;
        ld     = (m != mModeQ) || mPend[1];
        eR     = mPend[1];
        eTick  = (mPhase == DIV - 1);
        case (mModeQ)
            2'b01:   eCe = (mPhase == DIV - 1);
            2'b10:   eCe = mPend[0];
            2'b11:   eCe = 1'b1;
            default: eCe = 1'b0;
        endcase
        if (ld) eCe = 1'b0;
        mPhase = ld ? 0 : (mPhase + 1) % DIV;
        mModeQ = m;
        for (int b = 0; b < 2; b++) begin
            mPend[b] = 1'b0;
            if (mHist[b][1] != mLvl[b]) begin
                mRun[b]++;
                if (mRun[b] == DEB) begin
                    mLvl[b]  = ~mLvl[b];
                    mRun[b]  = 0;
                    mPend[b] = mLvl[b];
                end
            end else begin
                mRun[b] = 0;
            end
            mHist[b][1] = mHist[b][0];
            mHist[b][0] = raw[b];
        end
    endtask

    task automatic startSeq();
        cyc     = 0;
        ceCount = 0;
        ceFirst = 0;
        rCount  = 0;
        rFirst  = 0;
        ceLog.delete();
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic bs, input logic bc);
        @(negedge clk);
        bus.mode     = m;
        bus.btn_step = bs;
        bus.btn_clr  = bc;
        @(posedge clk);
        modelEdge(m, bs, bc);
        #1;
        cyc++;
        checkOutput("model");
        ceLog.push_back(bus.ce);
        if (bus.ce === 1'b1) begin
            ceCount++;
            if (ceFirst == 0) ceFirst = cyc;
        end
        if (bus.R === 1'b1) begin
            rCount++;
            if (rFirst == 0) rFirst = cyc;
        end
    endtask

    // Asserts reset between edges, checks outputs clear at once, releases away from an edge.
    task automatic applyReset(input string name);
        rn = 1'b0;
        #1;
        checkVal({name, " ce"},   int'(bus.ce),   0);
        checkVal({name, " R"},    int'(bus.R),    0);
        checkVal({name, " tick"}, int'(bus.tick), 0);
        modelReset();
        @(posedge clk);
        #3;
        rn = 1'b1;
    endtask

    initial begin
        vec_t tbl [9];
        logic bounce [4];
        logic [1:0] rMode;
        logic rBs, rBc;

        bus.mode     = 2'b00;
        bus.btn_step = 1'b0;
        bus.btn_clr  = 1'b0;
        rn           = 1'b0;
        applyReset("reset");

        // RUN from reset: first edge is the mode change, then ce/tick every 4 clocks.
        tbl[0] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        startSeq();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].mode, tbl[i].bs, tbl[i].bc);
            checkVal("run table", int'({bus.ce, bus.R, bus.tick}),
                     int'({tbl[i].ce, tbl[i].r, tbl[i].tick}));
        end

        // STEP: clean press held 10 clocks gives one ce, 6 clocks after the edge.
        for (int i = 0; i < 3; i++) applyStimulus(2'b10, 1'b0, 1'b0);
        startSeq();
        for (int i = 0; i < 10; i++) applyStimulus(2'b10, 1'b1, 1'b0);
        checkVal("step count", ceCount, 1);
        checkVal("step latency", ceFirst, 6);
        startSeq();
        for (int i = 0; i < 8; i++) applyStimulus(2'b10, 1'b0, 1'b0);
        checkVal("step release", ceCount, 0);

        // STEP: bounce 1,0,1,0 then stable high.
        bounce[0] = 1'b1; bounce[1] = 1'b0; bounce[2] = 1'b1; bounce[3] = 1'b0;
        startSeq();
        for (int i = 0; i < 4; i++) applyStimulus(2'b10, bounce[i], 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(2'b10, 1'b1, 1'b0);
        checkVal("bounce count", ceCount, 1);
        checkVal("bounce latency", ceFirst, 10);
        for (int i = 0; i < 8; i++) applyStimulus(2'b10, 1'b0, 1'b0);

        // FAST with a clear press: one-clock R, ce low only on that clock.
        for (int i = 0; i < 4; i++) applyStimulus(2'b11, 1'b0, 1'b0);
        checkVal("fast ce", int'(bus.ce), 1);
        startSeq();
        for (int i = 0; i < 10; i++) applyStimulus(2'b11, 1'b0, 1'b1);
        checkVal("clr R count", rCount, 1);
        checkVal("clr R cycle", rFirst, 6);
        checkVal("clr ce before", int'(ceLog[4]), 1);
        checkVal("clr ce during", int'(ceLog[5]), 0);
        checkVal("clr ce after", int'(ceLog[6]), 1);
        for (int i = 0; i < 8; i++) applyStimulus(2'b11, 1'b0, 1'b0);

        // STOP -> RUN at an arbitrary prescaler phase.
        for (int i = 0; i < int'($urandom_range(3, 9)); i++) applyStimulus(2'b00, 1'b0, 1'b0);
        startSeq();
        for (int i = 0; i < 7; i++) applyStimulus(2'b01, 1'b0, 1'b0);
        checkVal("switch ce", int'(ceLog[0]), 0);
        checkVal("switch first ce", ceFirst, 5);

        // Reset while ce is high in FAST, then release into RUN.
        for (int i = 0; i < 3; i++) applyStimulus(2'b11, 1'b0, 1'b0);
        checkVal("pre-reset ce", int'(bus.ce), 1);
        #4;
        applyReset("midreset");
        startSeq();
        for (int i = 0; i < 7; i++) applyStimulus(2'b01, 1'b0, 1'b0);
        checkVal("post-reset first ce", ceFirst, 5);
        checkVal("post-reset R", rCount, 0);

        // Randomized traffic: occasional mode changes, bouncy and held buttons, a mid-run reset.
        rMode = 2'b10;
        rBs   = 1'b0;
        rBc   = 1'b0;
        startSeq();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) rMode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rBs = ~rBs;
            if ($urandom_range(0, 7) == 0) rBc = ~rBc;
            applyStimulus(rMode, rBs, rBc);
            if (i == 300) begin
                #4;
                applyReset("randreset");
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
